// File: rtl/wb_result_stage.sv
// Write-back result stage: formats the completed value and hands it
// to the register file through a registered valid/ready output.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - upstream handshake (in_ready = skid empty)
//   wb_sel              - 0 ALU, 1 load, 2 PC+4, 3 immediate
//   alu_result, load_data, addr_low, funct3, pc, immediate
//                       - value sources and load formatting controls
//   reg_write, rd       - destination write request and index
//   wb_valid/wb_ready   - register-file handshake
//   wb_we, wb_rd, wb_data
//                       - presented write-back entry
//   instret             - retired-instruction counter
module wb_result_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       wb_sel,
   input  logic [XLEN-1:0]  alu_result,
   input  logic [XLEN-1:0]  load_data,
   input  logic [1:0]       addr_low,
   input  logic [2:0]       funct3,
   input  logic [XLEN-1:0]  pc,
   input  logic [XLEN-1:0]  immediate,
   input  logic             reg_write,
   input  logic [4:0]       rd,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic             wb_we,
   output logic [4:0]       wb_rd,
   output logic [XLEN-1:0]  wb_data,
   output logic [CNT_W-1:0] instret
);

   logic [7:0]      ld_b;
   logic [15:0]     ld_h;
   logic [XLEN-1:0] ld_val;
   logic [XLEN-1:0] fmt_data;
   logic            fmt_we;

   logic            out_valid_q, out_valid_d;
   logic            out_we_q, out_we_d;
   logic [4:0]      out_rd_q, out_rd_d;
   logic [XLEN-1:0] out_data_q, out_data_d;

   logic            skid_valid_q, skid_valid_d;
   logic            skid_we_q, skid_we_d;
   logic [4:0]      skid_rd_q, skid_rd_d;
   logic [XLEN-1:0] skid_data_q, skid_data_d;

   logic             in_ready_q, in_ready_d;
   logic [CNT_W-1:0] instret_q, instret_d;

   logic accept;
   logic retire;
   logic out_free;

   assign ld_b = load_data[{addr_low, 3'b000} +: 8];
   assign ld_h = load_data[{addr_low[1], 4'b0000} +: 16];

   always_comb begin
      ld_val = load_data;
      case (funct3)
         3'b000:  ld_val = {{(XLEN-8){ld_b[7]}}, ld_b};
         3'b001:  ld_val = {{(XLEN-16){ld_h[15]}}, ld_h};
         3'b100:  ld_val = {{(XLEN-8){1'b0}}, ld_b};
         3'b101:  ld_val = {{(XLEN-16){1'b0}}, ld_h};
         default: ld_val = load_data;
      endcase
   end

   always_comb begin
      fmt_data = alu_result;
      unique case (wb_sel)
         2'd0: fmt_data = alu_result;
         2'd1: fmt_data = ld_val;
         2'd2: fmt_data = pc + XLEN'(4);
         2'd3: fmt_data = immediate;
      endcase
   end

   assign fmt_we = reg_write && (rd != 5'd0);

   assign accept   = in_valid && in_ready_q;
   assign retire   = out_valid_q && wb_ready;
   assign out_free = !out_valid_q || retire;

   // Skid is drained before new input so entries retire in order.
   // Accept only happens with the skid empty, so the two never collide.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_we_d     = out_we_q;
      out_rd_d     = out_rd_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_we_d    = skid_we_q;
      skid_rd_d    = skid_rd_q;
      skid_data_d  = skid_data_q;
      if (out_free) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_we_d     = skid_we_q;
            out_rd_d     = skid_rd_q;
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            out_valid_d = 1'b1;
            out_we_d    = fmt_we;
            out_rd_d    = rd;
            out_data_d  = fmt_data;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_we_d    = fmt_we;
         skid_rd_d    = rd;
         skid_data_d  = fmt_data;
      end
      in_ready_d = !skid_valid_d;
      instret_d  = instret_q + CNT_W'(retire);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_we_q     <= 1'b0;
         out_rd_q     <= '0;
         out_data_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_we_q    <= 1'b0;
         skid_rd_q    <= '0;
         skid_data_q  <= '0;
         in_ready_q   <= 1'b1;
         instret_q    <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_we_q     <= out_we_d;
         out_rd_q     <= out_rd_d;
         out_data_q   <= out_data_d;
         skid_valid_q <= skid_valid_d;
         skid_we_q    <= skid_we_d;
         skid_rd_q    <= skid_rd_d;
         skid_data_q  <= skid_data_d;
         in_ready_q   <= in_ready_d;
         instret_q    <= instret_d;
      end
   end

   assign in_ready = in_ready_q;
   assign wb_valid = out_valid_q;
   assign wb_we    = out_we_q;
   assign wb_rd    = out_rd_q;
   assign wb_data  = out_data_q;
   assign instret  = instret_q;

endmodule

// File: tb/tb_wb_result_stage.sv
// Bench for wb_result_stage: directed literal cases plus a random
// stream checked each cycle against an in-order queue model.
module tb_wb_result_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  wb_sel;
   logic [31:0] alu_result;
   logic [31:0] load_data;
   logic [1:0]  addr_low;
   logic [2:0]  funct3;
   logic [31:0] pc;
   logic [31:0] immediate;
   logic        reg_write;
   logic [4:0]  rd;
   logic        wb_valid;
   logic        wb_ready;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [63:0] instret;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 0;

   always #5 clk = ~clk;

   wb_result_stage #(.XLEN(32), .CNT_W(64)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .wb_sel(wb_sel), .alu_result(alu_result),
      .load_data(load_data), .addr_low(addr_low),
      .funct3(funct3), .pc(pc), .immediate(immediate),
      .reg_write(reg_write), .rd(rd),
      .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .instret(instret)
   );

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
      end
   endtask

   // Reference formatting from the instruction-level rules.
   function automatic logic [31:0] ref_val(
      input logic [1:0] sel, input logic [31:0] alu,
      input logic [31:0] ld, input logic [1:0] al,
      input logic [2:0] f3, input logic [31:0] p,
      input logic [31:0] imm);
      logic [31:0] v;
      if (sel == 0) return alu;
      if (sel == 2) return p + 32'd4;
      if (sel == 3) return imm;
      if (f3 == 0 || f3 == 4) begin
         v = (ld >> (8 * al)) & 32'hFF;
         if (f3 == 0 && v >= 32'h80) v = v - 32'h100;
         return v;
      end
      if (f3 == 1 || f3 == 5) begin
         v = (ld >> (16 * (al / 2))) & 32'hFFFF;
         if (f3 == 1 && v >= 32'h8000) v = v - 32'h10000;
         return v;
      end
      return ld;
   endfunction

   typedef struct packed {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   ent_t        mq[$];
   logic [63:0] m_instret = 0;

   // Model: at most two entries in flight, retired in order.
   always @(posedge clk) begin
      bit   acc, ret;
      ent_t e;
      if (rst) begin
         mq.delete();
         m_instret = 0;
      end else begin
         acc = in_valid && (mq.size() < 2);
         ret = (mq.size() > 0) && wb_ready;
         e.we   = reg_write && (rd != 0);
         e.rd   = rd;
         e.data = ref_val(wb_sel, alu_result, load_data,
                          addr_low, funct3, pc, immediate);
         if (ret) begin
            void'(mq.pop_front());
            m_instret = m_instret + 1;
         end
         if (acc) mq.push_back(e);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("wb_valid", 64'(wb_valid), 64'(mq.size() > 0));
         chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
         chk("instret", instret, m_instret);
         if (mq.size() > 0) begin
            chk("wb_we", 64'(wb_we), 64'(mq[0].we));
            chk("wb_rd", 64'(wb_rd), 64'(mq[0].rd));
            chk("wb_data", 64'(wb_data), 64'(mq[0].data));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [1:0] s,
                         input logic [31:0] a,
                         input logic [31:0] ld,
                         input logic [1:0] al,
                         input logic [2:0] f3,
                         input logic [31:0] p,
                         input logic [31:0] im,
                         input logic rw,
                         input logic [4:0] r);
      in_valid   = 1'b1;
      wb_sel     = s;
      alu_result = a;
      load_data  = ld;
      addr_low   = al;
      funct3     = f3;
      pc         = p;
      immediate  = im;
      reg_write  = rw;
      rd         = r;
   endtask

   // One instruction with wb_ready=1; checks the presented value
   // in the following cycle, then lets it retire.
   task automatic one(input string nm,
                      input logic [1:0] s,
                      input logic [31:0] a,
                      input logic [31:0] ld,
                      input logic [1:0] al,
                      input logic [2:0] f3,
                      input logic [31:0] p,
                      input logic [31:0] im,
                      input logic [31:0] exp);
      set_in(s, a, ld, al, f3, p, im, 1'b1, 5'd7);
      tick();
      in_valid = 1'b0;
      chk({nm, "_valid"}, 64'(wb_valid), 64'd1);
      chk({nm, "_data"}, 64'(wb_data), 64'(exp));
      tick();
   endtask

   initial begin
      rst = 1'b1;
      wb_ready = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      in_valid = 1'b0;
      tick();
      chk_en = 1;
      tick();
      rst = 1'b0;
      chk("rst_valid", 64'(wb_valid), 64'd0);
      chk("rst_we", 64'(wb_we), 64'd0);
      chk("rst_rd", 64'(wb_rd), 64'd0);
      chk("rst_data", 64'(wb_data), 64'd0);
      chk("rst_instret", instret, 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      wb_ready = 1'b1;
      set_in(0, 32'h1234, 0, 0, 0, 0, 0, 1'b1, 5'd5);
      tick();
      in_valid = 1'b0;
      chk("t1_valid", 64'(wb_valid), 64'd1);
      chk("t1_we", 64'(wb_we), 64'd1);
      chk("t1_rd", 64'(wb_rd), 64'd5);
      chk("t1_data", 64'(wb_data), 64'h1234);
      tick();
      chk("t1_instret", instret, 64'd1);

      one("lb3", 1, 0, 32'h80FF_7F01, 3, 3'b000, 0, 0,
          32'hFFFF_FF80);
      one("lbu2", 1, 0, 32'h80FF_7F01, 2, 3'b100, 0, 0,
          32'h0000_00FF);
      one("lh2", 1, 0, 32'h80FF_7F01, 2, 3'b001, 0, 0,
          32'hFFFF_80FF);
      one("lhu0", 1, 0, 32'h80FF_7F01, 0, 3'b101, 0, 0,
          32'h0000_7F01);
      one("pc4", 2, 0, 0, 0, 0, 32'hFFFF_FFFC, 0,
          32'h0000_0000);
      one("imm", 3, 0, 0, 0, 0, 0, 32'hABCD_E000,
          32'hABCD_E000);

      set_in(0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 1'b1, 5'd0);
      tick();
      in_valid = 1'b0;
      chk("rd0_valid", 64'(wb_valid), 64'd1);
      chk("rd0_we", 64'(wb_we), 64'd0);
      chk("rd0_data", 64'(wb_data), 64'hDEAD_BEEF);
      tick();
      chk("rd0_instret", instret, 64'd8);

      // Back-pressure: A out, B skid, C held upstream.
      wb_ready = 1'b0;
      set_in(0, 32'hA, 0, 0, 0, 0, 0, 1'b1, 5'd1);
      tick();
      set_in(0, 32'hB, 0, 0, 0, 0, 0, 1'b1, 5'd2);
      chk("bp_a0", 64'(wb_data), 64'hA);
      chk("bp_rdy0", 64'(in_ready), 64'd1);
      tick();
      set_in(0, 32'hC, 0, 0, 0, 0, 0, 1'b1, 5'd3);
      chk("bp_rdy1", 64'(in_ready), 64'd0);
      chk("bp_a1", 64'(wb_data), 64'hA);
      tick();
      chk("bp_rdy2", 64'(in_ready), 64'd0);
      chk("bp_a2", 64'(wb_data), 64'hA);
      chk("bp_rd2", 64'(wb_rd), 64'd1);
      wb_ready = 1'b1;
      tick();
      chk("bp_b", 64'(wb_data), 64'hB);
      chk("bp_rdy3", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      chk("bp_c", 64'(wb_data), 64'hC);
      chk("bp_c_valid", 64'(wb_valid), 64'd1);
      tick();
      chk("bp_empty", 64'(wb_valid), 64'd0);
      chk("bp_instret", instret, 64'd11);

      // Reset with A in output and B in skid.
      wb_ready = 1'b0;
      set_in(0, 32'h11, 0, 0, 0, 0, 0, 1'b1, 5'd4);
      tick();
      set_in(0, 32'h22, 0, 0, 0, 0, 0, 1'b1, 5'd6);
      tick();
      in_valid = 1'b0;
      chk("pre_rst_rdy", 64'(in_ready), 64'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wb_ready = 1'b1;
      chk("mid_rst_valid", 64'(wb_valid), 64'd0);
      chk("mid_rst_rdy", 64'(in_ready), 64'd1);
      chk("mid_rst_instret", instret, 64'd0);
      tick();
      tick();
      chk("post_rst_valid", 64'(wb_valid), 64'd0);
      chk("post_rst_instret", instret, 64'd0);

      // Random stream against the model.
      for (int i = 0; i < 3000; i++) begin
         rst       = ($urandom_range(0, 249) == 0);
         wb_ready  = ($urandom_range(0, 3) != 0);
         in_valid  = ($urandom_range(0, 2) != 0);
         wb_sel    = 2'($urandom);
         alu_result = $urandom;
         load_data = $urandom;
         addr_low  = 2'($urandom);
         funct3    = 3'($urandom);
         pc        = ($urandom_range(0, 7) == 0) ?
                     32'hFFFF_FFFC : $urandom;
         immediate = $urandom;
         reg_write = 1'($urandom);
         rd        = ($urandom_range(0, 5) == 0) ?
                     5'd0 : 5'($urandom);
         tick();
      end
      rst = 1'b0;
      in_valid = 1'b0;
      wb_ready = 1'b1;
      tick();
      tick();
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_result_stage.md
Name: wb_result_stage

Overview:
- Write-back end of the execute datapath; the counterpart of the ALU operand-selection side.
- Accepts one completed instruction per cycle: ALU result, raw load word, PC, immediate, destination register.
- Selects and formats the write-back value, then presents it to the register file through a registered valid/ready interface.
- Holds a one-entry skid buffer to absorb register-file back-pressure, and maintains the retired-instruction counter.

Parameters:
- XLEN, 32, data width of all value paths.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  stage can accept this cycle.
- wb_sel  input  2  value select: 0 ALU, 1 load, 2 PC+4, 3 immediate.
- alu_result  input  XLEN  ALU output.
- load_data  input  XLEN  raw aligned memory word.
- addr_low  input  2  byte offset of the load address.
- funct3  input  3  load width/sign code.
- pc  input  XLEN  instruction PC.
- immediate  input  XLEN  decoded immediate (LUI path).
- reg_write  input  1  instruction writes rd.
- rd  input  5  destination register index.
- wb_valid  output  1  write-back entry valid.
- wb_ready  input  1  register file accepts the entry.
- wb_we  output  1  write enable for the presented entry.
- wb_rd  output  5  destination index.
- wb_data  output  XLEN  formatted write-back value.
- instret  output  CNT_W  retired-instruction count.

Behaviour:
- Reset (synchronous, active-high): wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, instret=0, skid buffer empty, in_ready=1.
- Reset mid-operation: all buffered entries are dropped with no write and no instret increment.
- Accept/retire definitions: accept = in_valid && in_ready; retire = wb_valid && wb_ready.
- in_ready is registered and equals "skid empty"; it is independent of wb_ready in the same cycle.
- Latency: an entry accepted in cycle N appears on wb_* in cycle N+1 when the output register is free or retiring in cycle N.
- Output register loads from the skid buffer first, then from the input, so entries retire in order.
- Skid buffer: if accept occurs while the output register holds an entry that is not retiring, the new entry goes to the skid and in_ready=0 from the next cycle.
- Skid drain: on the next retire the skid entry moves to the output register and in_ready returns to 1 the cycle after.
- Simultaneous retire and accept with skid empty: the new entry goes directly to the output register and wb_valid stays 1.
- wb_* outputs stay stable while wb_valid && !wb_ready.
- Value formatting (computed before registering):
  - sel0: alu_result.
  - sel2: pc+4, wrapping modulo 2^XLEN.
  - sel3: immediate.
  - sel1 (load): b = byte at addr_low; h = halfword at addr_low[1] (addr_low[0] ignored).
    - funct3=000: sign-extend b.
    - funct3=001: sign-extend h.
    - funct3=010: full word.
    - funct3=100: zero-extend b.
    - funct3=101: zero-extend h.
    - Any other funct3: full word.
- wb_we = reg_write && (rd != 0); wb_data and wb_rd are still presented when wb_we=0.
- instret increments by 1 on every retire, including entries with wb_we=0, and wraps to 0 at all-ones.

Test Plan:
- After reset, wb_ready=1; send sel0 alu_result=0x0000_1234, rd=5, reg_write=1 -> next cycle wb_valid=1, wb_we=1, wb_rd=5, wb_data=0x0000_1234; instret=1 one cycle later.
- sel1 with load_data=0x80FF_7F01:
  - funct3=000, addr_low=3 -> wb_data=0xFFFF_FF80.
  - funct3=100, addr_low=2 -> 0x0000_00FF.
  - funct3=001, addr_low=2 -> 0xFFFF_80FF.
  - funct3=101, addr_low=0 -> 0x0000_7F01.
- sel2 pc=0xFFFF_FFFC -> wb_data=0x0000_0000; sel3 immediate=0xABCD_E000 -> 0xABCD_E000.
- rd=0, reg_write=1, alu_result=0xDEAD_BEEF -> wb_valid=1, wb_we=0, wb_data=0xDEAD_BEEF; instret still increments.
- Hold wb_ready=0 and stream entries A, B, C -> A on output, B in skid, in_ready=0, C held upstream; raise wb_ready -> A, B, C retire in order, one per cycle, with no loss or duplication.
- With A in output and B in skid, assert rst for 1 cycle -> wb_valid=0, in_ready=1, instret=0; no write of A or B is observed.
